// File: rtl/filtro_pkg.sv
`default_nettype none
// ============================================================================
// filtro_pkg: shared FIR-path parameter defaults and sequencer state encoding.
// Rev 1.0
// ============================================================================
package filtro_pkg;

  localparam int DEF_W     = 24;
  localparam int DEF_TAPS  = 5;
  localparam int DEF_AW    = 3;
  localparam int DEF_ACC_W = 51;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MULT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    MULT  = ST_MULT,
    DRAIN = ST_DRAIN,
    HOLD  = ST_HOLD
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/linea_retardo.sv
`default_nettype none
// ============================================================================
// linea_retardo: TAPS x W sample delay line, load-enabled shift, async clear.
// Rev 1.0
// ============================================================================
module linea_retardo
  import filtro_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int TAPS = DEF_TAPS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic [W-1:0]             i_muestra,
  output logic [TAPS-1:0][W-1:0]   o_linea
);

  logic [TAPS-1:0][W-1:0] r_linea;

  // Entry 0 holds the newest sample; older samples move toward TAPS-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_linea <= '0;
    end else if (i_load) begin
      r_linea <= {r_linea[TAPS-2:0], i_muestra};
    end
  end

  assign o_linea = r_linea;

endmodule
`default_nettype wire

// File: rtl/secuenciador_mac.sv
`default_nettype none
// ============================================================================
// secuenciador_mac: schedules the shared 24x24 multiplier as a FIR MAC engine.
// Rev 1.0
// ============================================================================
module secuenciador_mac
  import filtro_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int TAPS  = DEF_TAPS,
  parameter int AW    = DEF_AW,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [W-1:0]       muestra_in,
  output logic               ocupado,
  output logic [AW-1:0]      coef_addr,
  input  logic [W-1:0]       coef_data,
  output logic [W-1:0]       mult_a,
  output logic [W-1:0]       mult_b,
  input  logic [2*W-1:0]     mult_p,
  output logic [ACC_W-1:0]   resultado,
  output logic               valido,
  input  logic               listo
);

  localparam logic [AW-1:0] C_K_LAST = AW'(TAPS - 1);

  estado_t                r_state;
  estado_t                w_state_nxt;
  logic [AW-1:0]          r_k;
  logic [ACC_W-1:0]       r_acc;
  logic [2*W-1:0]         r_p_reg;
  logic                   r_p_val;
  logic                   w_accept;
  logic [TAPS-1:0][W-1:0] w_linea;
  logic [W-1:0]           w_tap;
  logic [ACC_W-1:0]       w_p_ext;

  linea_retardo #(
    .W    (W),
    .TAPS (TAPS)
  ) u_linea (
    .clk       (clk),
    .rst       (reset),
    .i_load    (w_accept),
    .i_muestra (muestra_in),
    .o_linea   (w_linea)
  );

  assign w_p_ext = ACC_W'($signed(r_p_reg));

  always_comb begin
    w_tap = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (r_k == AW'(i)) w_tap = w_linea[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    ocupado     = 1'b1;
    valido      = 1'b0;
    resultado   = '0;
    coef_addr   = '0;
    mult_a      = '0;
    mult_b      = '0;
    case (r_state)
      IDLE: begin
        ocupado = 1'b0;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = MULT;
        end
      end
      MULT: begin
        coef_addr = r_k;
        mult_a    = w_tap;
        mult_b    = coef_data;
        if (r_k == C_K_LAST) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_state_nxt = HOLD;
      end
      HOLD: begin
        valido    = 1'b1;
        resultado = r_acc;
        // A new run may start on the same edge the result is consumed.
        if (listo) begin
          if (start) begin
            w_accept    = 1'b1;
            w_state_nxt = MULT;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The product is registered one cycle before it is accumulated, so the
  // last tap's product is folded in during DRAIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k     <= '0;
      r_acc   <= '0;
      r_p_reg <= '0;
      r_p_val <= 1'b0;
    end else if (w_accept) begin
      r_k     <= '0;
      r_acc   <= '0;
      r_p_val <= 1'b0;
    end else begin
      case (r_state)
        MULT: begin
          r_p_reg <= mult_p;
          r_p_val <= 1'b1;
          if (r_p_val) r_acc <= r_acc + w_p_ext;
          if (r_k != C_K_LAST) r_k <= r_k + AW'(1);
        end
        DRAIN: begin
          r_acc   <= r_acc + w_p_ext;
          r_p_val <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_mac.sv
`default_nettype none
// ============================================================================
// tb_secuenciador_mac: scoreboard bench with a sum-of-products reference model.
// Rev 1.0
// ============================================================================
module tb_secuenciador_mac;
  import filtro_pkg::*;

  localparam int W = 24, TAPS = 5, AW = 3, ACC_W = 51, LAT = TAPS + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             listo = 1'b1;
  logic [W-1:0]     muestra_in = '0;
  logic [W-1:0]     coef_data, mult_a, mult_b;
  logic [AW-1:0]    coef_addr;
  logic [2*W-1:0]   mult_p;
  logic [ACC_W-1:0] resultado;
  logic             ocupado, valido;

  secuenciador_mac #(.W(W), .TAPS(TAPS), .AW(AW), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .muestra_in (muestra_in),
    .ocupado    (ocupado),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_p     (mult_p),
    .resultado  (resultado),
    .valido     (valido),
    .listo      (listo)
  );

  always #5 clk = ~clk;

  // Coefficient ROM and signed multiplier living outside the DUT.
  logic signed [W-1:0] rom [TAPS];
  always_comb begin
    coef_data = '0;
    for (int i = 0; i < TAPS; i++) if (coef_addr == AW'(i)) coef_data = rom[i];
  end
  assign mult_p = {{W{mult_a[W-1]}}, mult_a} * {{W{mult_b[W-1]}}, mult_b};

  typedef struct { logic [ACC_W-1:0] val; int cyc; } exp_t;
  exp_t                sb[$];
  logic signed [W-1:0] hist[$];
  int                  cyc = 0;
  int                  errors = 0, checks = 0;
  bit                  rand_listo = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // y[n] = sum c[k]*x[n-k] over the accepted sample history (newest first).
  function automatic logic [ACC_W-1:0] model_push(logic signed [W-1:0] x);
    longint s = 0;
    hist.push_front(x);
    if (hist.size() > TAPS) void'(hist.pop_back());
    for (int k = 0; k < hist.size(); k++) s += longint'(rom[k]) * longint'(hist[k]);
    return ACC_W'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_listo) listo = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_accept();
    int n = 0;
    while (ocupado && !(valido && listo)) begin
      tick();
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL wait_accept: timeout, ocupado=%0b required 0", ocupado);
        return;
      end
    end
  endtask

  task automatic send(logic [W-1:0] x);
    exp_t e;
    wait_accept();
    start = 1'b1;
    muestra_in = x;
    e.val = model_push(x);
    e.cyc = cyc + 1 + LAT;
    sb.push_back(e);
    tick();
    start = 1'b0;
    muestra_in = W'($urandom);
  endtask

  // Busy cycle; a start pulsed here lands in MULT/DRAIN or HOLD with listo=0.
  task automatic busy_cycle();
    if (ocupado && !(valido && listo) && $urandom_range(0, 1) == 1) begin
      start = 1'b1;
      muestra_in = W'($urandom);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0) begin
      tick();
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL drain: outstanding=%0d required 0", sb.size());
        sb.delete();
        return;
      end
    end
    tick();
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_ocupado"},   64'(ocupado),   64'd0);
    chk({tag, "_valido"},    64'(valido),    64'd0);
    chk({tag, "_resultado"}, 64'(resultado), 64'd0);
    chk({tag, "_coef_addr"}, 64'(coef_addr), 64'd0);
    chk({tag, "_mult_a"},    64'(mult_a),    64'd0);
    chk({tag, "_mult_b"},    64'(mult_b),    64'd0);
  endtask

  // Monitor: latency on valido rise, stability under backpressure, value on handshake.
  logic             prev_valido = 1'b0, prev_listo = 1'b0;
  logic [ACC_W-1:0] prev_res = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_valido = 1'b0;
      prev_listo  = 1'b0;
      prev_res    = '0;
    end else begin
      if (valido && !prev_valido) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL latency: valido rose with nothing expected");
        end else chk("latency_cycle", 64'(cyc), 64'(sb[0].cyc));
      end
      if (valido && prev_valido && !prev_listo) chk("hold_stable", 64'(resultado), 64'(prev_res));
      if (valido && listo) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL resultado: unexpected result %0h, none pending", resultado);
        end else begin
          chk("resultado", 64'(resultado), 64'(sb[0].val));
          void'(sb.pop_front());
        end
      end
      prev_valido = valido;
      prev_listo  = listo;
      prev_res    = resultado;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rom = '{24'sd1, 24'sd2, 24'sd3, 24'sd4, 24'sd5};
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    reset = 1'b0;
    tick();

    // Impulse response then step response, back-to-back with listo high.
    send(24'd1);
    repeat (4) send(24'd0);
    drain();
    repeat (5) send(24'd10);
    drain();

    // Backpressure with ignored start pulses while holding.
    send(24'h000123);
    listo = 1'b0;
    for (int n = 0; n < 30 && !valido; n++) tick();
    chk("bp_valido_seen", 64'(valido), 64'd1);
    for (int i = 0; i < 7; i++) begin
      start = (i == 2 || i == 3);
      muestra_in = W'($urandom);
      tick();
    end
    start = 1'b0;
    listo = 1'b1;
    tick();
    chk("bp_single_ocupado", 64'(ocupado), 64'd0);
    chk("bp_single_valido", 64'(valido), 64'd0);
    drain();

    // Asynchronous reset in the middle of MULT at k=2.
    send(24'h00ABCD);
    tick();
    tick();
    chk("mid_run_coef_addr", 64'(coef_addr), 64'd2);
    reset = 1'b1;
    #1;
    chk_zero_outputs("async_reset");
    sb.delete();
    hist.delete();
    tick();
    reset = 1'b0;
    tick();
    send(24'd7);
    drain();

    // Sign handling at the most negative coefficient.
    rom = '{-24'sd8388608, 24'sd0, 24'sd0, 24'sd0, 24'sd0};
    send(24'hFFFFFF);
    drain();

    // Randomised coefficients, samples, gaps, listo and spurious starts.
    for (int k = 0; k < TAPS; k++) rom[k] = W'($urandom);
    rand_listo = 1;
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(0, 4)) busy_cycle();
      send(W'($urandom));
    end
    drain();
    rand_listo = 0;
    listo = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
